// File: rtl/ll8_txmac_pkg.sv
// Shared types and default widths for the LocalLink-to-GMII TX MAC feeder.
package ll8_txmac_pkg;

    localparam int unsigned MAX_LEN_DEF = 9000;
    localparam int unsigned LEN_W_DEF   = 14;
    localparam int unsigned STAT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_XFER,
        ST_DROP_ERR,
        ST_DROP,
        ST_GAP
    } state_e;

endpackage

// File: rtl/ll8_txmac_feeder_sat_ctr.sv
// Saturating event counter: holds at all-ones once reached.
module sat_ctr #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ll8_txmac_feeder.sv
// Zero-latency bridge from an 8-bit LocalLink TX FIFO to the GMII TX MAC,
// with abort signalling for underrun, oversize and malformed frames.
module ll8_txmac_feeder
    import ll8_txmac_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned STAT_W  = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        ll_data,
    input  logic              ll_sof,
    input  logic              ll_eof,
    input  logic              ll_src_rdy,
    output logic              ll_dst_rdy,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              tx_error,
    input  logic              tx_ack,
    output logic [STAT_W-1:0] frames_ok,
    output logic [STAT_W-1:0] frames_err,
    output logic [STAT_W-1:0] orphans
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_inc;
    logic             inc_ok, inc_err, inc_orph;

    assign len_inc = len_q + LEN_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // Outputs are gated by reset so the MAC and FIFO see idle while it is held.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ll_dst_rdy = 1'b0;
        tx_valid   = 1'b0;
        tx_error   = 1'b0;
        tx_data    = '0;
        inc_ok     = 1'b0;
        inc_err    = 1'b0;
        inc_orph   = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (ll_src_rdy) begin
                        if (ll_sof) begin
                            state_d = ST_WAIT_ACK;
                        end else begin
                            ll_dst_rdy = 1'b1;
                            inc_orph   = 1'b1;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    tx_valid   = 1'b1;
                    tx_data    = ll_data;
                    ll_dst_rdy = tx_ack;
                    if (tx_ack) begin
                        len_d = LEN_W'(1);
                        if (ll_eof) begin
                            inc_ok  = 1'b1;
                            state_d = ST_GAP;
                        end else if (LEN_W'(1) == LEN_MAX) begin
                            state_d = ST_DROP_ERR;
                        end else begin
                            state_d = ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    tx_data = ll_data;
                    if (!ll_src_rdy) begin
                        tx_error = 1'b1;
                        inc_err  = 1'b1;
                        state_d  = ST_DROP;
                    end else if (ll_sof) begin
                        // Leave the new sof unconsumed so it starts cleanly after GAP.
                        tx_error = 1'b1;
                        inc_err  = 1'b1;
                        state_d  = ST_GAP;
                    end else begin
                        tx_valid   = 1'b1;
                        ll_dst_rdy = 1'b1;
                        len_d      = len_inc;
                        if (ll_eof) begin
                            inc_ok  = 1'b1;
                            state_d = ST_GAP;
                        end else if (len_inc == LEN_MAX) begin
                            state_d = ST_DROP_ERR;
                        end
                    end
                end
                ST_DROP_ERR: begin
                    tx_error = 1'b1;
                    inc_err  = 1'b1;
                    state_d  = ST_DROP;
                end
                ST_DROP: begin
                    if (ll_src_rdy) begin
                        if (ll_sof) begin
                            state_d = ST_GAP;
                        end else begin
                            ll_dst_rdy = 1'b1;
                            if (ll_eof) begin
                                state_d = ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    sat_ctr #(.W(STAT_W)) u_ok_ctr (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc_ok),
        .count_o (frames_ok)
    );

    sat_ctr #(.W(STAT_W)) u_err_ctr (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc_err),
        .count_o (frames_err)
    );

    sat_ctr #(.W(STAT_W)) u_orph_ctr (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc_orph),
        .count_o (orphans)
    );

endmodule

// File: tb/tb_ll8_txmac_feeder.sv
// Bench for ll8_txmac_feeder: LocalLink source, reactive MAC model and a
// frame-level expectation of what the MAC should receive.
module tb_ll8_txmac_feeder;

    localparam int unsigned MAXL   = 120;
    localparam int unsigned LW     = 7;
    localparam int unsigned SW     = 4;
    localparam int          SAT    = (1 << SW) - 1;
    localparam int          BUDGET = 4000;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    ll_data;
    logic          ll_sof, ll_eof, ll_src_rdy, ll_dst_rdy;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_error, tx_ack;
    logic [SW-1:0] frames_ok, frames_err, orphans;

    always #4 clk = ~clk;

    ll8_txmac_feeder #(.MAX_LEN(MAXL), .LEN_W(LW), .STAT_W(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ll_data    (ll_data),
        .ll_sof     (ll_sof),
        .ll_eof     (ll_eof),
        .ll_src_rdy (ll_src_rdy),
        .ll_dst_rdy (ll_dst_rdy),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_error   (tx_error),
        .tx_ack     (tx_ack),
        .frames_ok  (frames_ok),
        .frames_err (frames_err),
        .orphans    (orphans)
    );

    typedef struct {
        int orph; int idle; int len; int stall_at; int stall_n; int trunc_at; int ack_dly;
    } frame_t;
    typedef struct { bit vld; logic [7:0] d; bit sof; bit eof; } item_t;
    typedef struct { int n; bit err; bit dok; int gap; } rec_t;
    typedef struct { frame_t f; int n; bit err; int ok; int ferr; int orph; } vec_t;

    int    total = 0;
    int    bad   = 0;
    int    salt;
    item_t stream[$];
    int    ack_q[$];
    rec_t  recs[$];
    rec_t  cur;
    bit    mon_in, mon_pend, mon_acked, adv, next_ack;
    int    mon_fidx, mon_gap, mac_st, mac_cnt, viol;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int fid, input int k);
        int v;
        v = fid * 53 + k * 13 + salt;
        return v[7:0];
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // What the MAC must receive: bytes up to the first cut point, error if short.
    function automatic void model(input frame_t f, output int n, output bit e);
        n = f.len;
        if (f.stall_at >= 0 && f.stall_at < n) n = f.stall_at;
        if (f.trunc_at >= 0 && f.trunc_at < n) n = f.trunc_at;
        if (n > int'(MAXL)) n = int'(MAXL);
        e = (n < f.len);
    endfunction

    task automatic load(input frame_t f, input int fid);
        item_t it;
        int    nb;
        nb = (f.trunc_at >= 0) ? f.trunc_at : f.len;
        for (int i = 0; i < f.idle; i++) begin
            it = '{1'b0, 8'h00, 1'b0, 1'b0};
            stream.push_back(it);
        end
        for (int i = 0; i < f.orph; i++) begin
            it = '{1'b1, 8'($urandom), 1'b0, 1'($urandom_range(0, 1))};
            stream.push_back(it);
        end
        for (int k = 0; k < nb; k++) begin
            if (k == f.stall_at) begin
                for (int s = 0; s < f.stall_n; s++) begin
                    it = '{1'b0, 8'h00, 1'b0, 1'b0};
                    stream.push_back(it);
                end
            end
            it = '{1'b1, fbyte(fid, k), (k == 0), (f.trunc_at < 0 && k == f.len - 1)};
            stream.push_back(it);
        end
        ack_q.push_back(f.ack_dly);
    endtask

    task automatic sample();
        bit eu;
        eu = 1'b0;
        if (tx_valid && tx_error) viol++;
        if (mon_pend) begin
            if (tx_error) begin
                cur.err = 1'b1;
                eu      = 1'b1;
            end
            recs.push_back(cur);
            mon_pend = 1'b0;
        end
        if (!mon_in) begin
            if (tx_valid) begin
                mon_in    = 1'b1;
                mon_acked = 1'b0;
                cur       = '{0, 1'b0, 1'b1, mon_gap};
            end else begin
                mon_gap++;
            end
        end
        if (mon_in) begin
            if (tx_valid) begin
                if (mon_acked || tx_ack) begin
                    mon_acked = 1'b1;
                    if (tx_data !== fbyte(mon_fidx, cur.n)) cur.dok = 1'b0;
                    cur.n++;
                end
            end else begin
                cur.err  = tx_error;
                eu       = eu | tx_error;
                mon_in   = 1'b0;
                mon_pend = 1'b1;
                mon_fidx++;
                mon_gap  = 1;
            end
        end
        if (tx_error && !eu) viol++;
        // MAC: hold off for ack_dly cycles after tx_valid rises, then pulse tx_ack.
        next_ack = 1'b0;
        if (!tx_valid) begin
            mac_st = 0;
        end else begin
            if (mac_st == 0) begin
                mac_cnt = 0;
                if (ack_q.size() > 0) mac_cnt = ack_q.pop_front();
                mac_st = 1;
            end
            if (mac_st == 1) begin
                if (tx_ack) mac_st = 2;
                else if (mac_cnt == 0) next_ack = 1'b1;
                else mac_cnt--;
            end
        end
        adv = (stream.size() > 0) && (!stream[0].vld || ll_dst_rdy);
    endtask

    task automatic apply();
        if (adv) void'(stream.pop_front());
        adv    = 1'b0;
        tx_ack = next_ack;
        if (stream.size() > 0) begin
            ll_src_rdy = stream[0].vld;
            ll_data    = stream[0].d;
            ll_sof     = stream[0].sof;
            ll_eof     = stream[0].eof;
        end else begin
            ll_src_rdy = 1'b0;
            ll_data    = 8'h00;
            ll_sof     = 1'b0;
            ll_eof     = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic clear_env();
        ll_src_rdy = 1'b0; ll_sof = 1'b0; ll_eof = 1'b0; ll_data = 8'h00; tx_ack = 1'b0;
        stream.delete(); ack_q.delete(); recs.delete();
        mon_in = 1'b0; mon_pend = 1'b0; mon_acked = 1'b0; adv = 1'b0; next_ack = 1'b0;
        mon_fidx = 0; mon_gap = 99; mac_st = 0; mac_cnt = 0; viol = 0;
        cur = '{0, 1'b0, 1'b1, 0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_env();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run(input string tag, input frame_t fr[$]);
        int cyc;
        cyc = 0;
        do_reset();
        foreach (fr[i]) load(fr[i], i);
        apply();
        while (stream.size() > 0 && cyc < BUDGET) begin
            step();
            cyc++;
        end
        chk({tag, "_drained"}, int'(cyc < BUDGET), 1);
        repeat (8) step();
    endtask

    task automatic check_frames(input string tag, input frame_t fr[$], input int ok_e,
                                input int err_e, input int orph_e, input int n_e[$], input bit e_e[$]);
        chk({tag, "_nframes"}, recs.size(), fr.size());
        for (int i = 0; i < fr.size() && i < recs.size(); i++) begin
            chk($sformatf("%s_f%0d_bytes", tag, i), recs[i].n, n_e[i]);
            chk($sformatf("%s_f%0d_err", tag, i), int'(recs[i].err), int'(e_e[i]));
            chk($sformatf("%s_f%0d_data", tag, i), int'(recs[i].dok), 1);
            chk($sformatf("%s_f%0d_gap", tag, i), int'(recs[i].gap >= 1), 1);
        end
        chk({tag, "_frames_ok"}, int'(frames_ok), ok_e);
        chk({tag, "_frames_err"}, int'(frames_err), err_e);
        chk({tag, "_orphans"}, int'(orphans), orph_e);
        chk({tag, "_protocol"}, viol, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl[10];
        frame_t fq[$];
        int     nq[$];
        bit     eq[$];
        frame_t f;
        int     n, g, e_ok, e_err, e_orph;
        bit     e;
        bit     prev_trunc;

        salt  = int'($urandom_range(0, 255));
        reset = 1'b1;
        clear_env();
        #3;
        chk("reset_dst_rdy", int'(ll_dst_rdy), 0);
        chk("reset_tx_valid", int'(tx_valid), 0);

        //            orph idle len   stall   sn trunc ack    n    err ok ferr orph
        tbl[0] = '{'{0, 0, 60,  -1, 0, -1, 3}, 60,  1'b0, 1, 0, 0};
        tbl[1] = '{'{3, 2, 10,  -1, 0, -1, 0}, 10,  1'b0, 1, 0, 3};
        tbl[2] = '{'{0, 0, 100, 40, 5, -1, 1}, 40,  1'b1, 0, 1, 0};
        tbl[3] = '{'{0, 0, 128, -1, 0, -1, 2}, 120, 1'b1, 0, 1, 0};
        tbl[4] = '{'{0, 0, 120, -1, 0, -1, 0}, 120, 1'b0, 1, 0, 0};
        tbl[5] = '{'{0, 0, 121, -1, 0, -1, 0}, 120, 1'b1, 0, 1, 0};
        tbl[6] = '{'{0, 0, 1,   -1, 0, -1, 5}, 1,   1'b0, 1, 0, 0};
        tbl[7] = '{'{0, 0, 2,   1,  3, -1, 0}, 1,   1'b1, 0, 1, 0};
        tbl[8] = '{'{20, 1, 5,  -1, 0, -1, 0}, 5,   1'b0, 1, 0, 15};
        tbl[9] = '{'{0, 0, 119, -1, 0, -1, 4}, 119, 1'b0, 1, 0, 0};

        foreach (tbl[v]) begin
            fq.delete(); nq.delete(); eq.delete();
            fq.push_back(tbl[v].f); nq.push_back(tbl[v].n); eq.push_back(tbl[v].err);
            run($sformatf("vec%0d", v), fq);
            check_frames($sformatf("vec%0d", v), fq, tbl[v].ok, tbl[v].ferr, tbl[v].orph, nq, eq);
        end

        // Back-to-back frames with no idle between them.
        fq = '{'{0, 0, 10, -1, 0, -1, 2}, '{0, 0, 20, -1, 0, -1, 2}};
        nq = '{10, 20}; eq = '{1'b0, 1'b0};
        run("b2b", fq);
        check_frames("b2b", fq, 2, 0, 0, nq, eq);

        // sof at byte 5 aborts, then the new frame goes out from its own sof.
        fq = '{'{0, 0, 12, -1, 0, 5, 1}, '{0, 0, 12, -1, 0, -1, 1}};
        nq = '{5, 12}; eq = '{1'b1, 1'b0};
        run("midsof", fq);
        check_frames("midsof", fq, 1, 1, 0, nq, eq);

        // Underrun, drain, then a clean frame.
        fq = '{'{0, 0, 100, 40, 5, -1, 3}, '{0, 2, 8, -1, 0, -1, 0}};
        nq = '{40, 8}; eq = '{1'b1, 1'b0};
        run("undr", fq);
        check_frames("undr", fq, 1, 1, 0, nq, eq);

        // Reset asserted mid-frame forces outputs low without a clock edge.
        do_reset();
        f = '{3, 0, 60, -1, 0, -1, 1};
        load(f, 0);
        apply();
        g = 0;
        while (!(mon_acked && cur.n >= 5) && g < 500) begin
            step();
            g++;
        end
        chk("rst_reach_xfer", int'(g < 500), 1);
        chk("rst_pre_orphans", int'(orphans), 3);
        chk("rst_pre_valid", int'(tx_valid), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_valid", int'(tx_valid), 0);
        chk("rst_async_dst_rdy", int'(ll_dst_rdy), 0);
        chk("rst_async_error", int'(tx_error), 0);
        chk("rst_async_data", int'(tx_data), 0);
        chk("rst_async_orphans", int'(orphans), 0);
        clear_env();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) step();
        chk("rst_post_ok", int'(frames_ok), 0);
        chk("rst_post_err", int'(frames_err), 0);
        chk("rst_post_valid", int'(tx_valid), 0);

        // Good-frame counter saturates.
        fq.delete(); nq.delete(); eq.delete();
        for (int i = 0; i < 18; i++) begin
            fq.push_back('{0, 0, 3, -1, 0, -1, 0});
            nq.push_back(3);
            eq.push_back(1'b0);
        end
        run("sat", fq);
        check_frames("sat", fq, 15, 0, 0, nq, eq);

        // Random batches against the frame-level model.
        for (int b = 0; b < 6; b++) begin
            fq.delete(); nq.delete(); eq.delete();
            e_ok = 0; e_err = 0; e_orph = 0;
            prev_trunc = 1'b0;
            for (int i = 0; i < 6; i++) begin
                int r;
                f = '{0, 0, 0, -1, 0, -1, 0};
                if ($urandom_range(0, 3) == 0) f.orph = int'($urandom_range(1, 3));
                f.idle = int'($urandom_range(0, 2));
                r = int'($urandom_range(0, 9));
                if (r == 0) f.len = 1;
                else if (r == 1) f.len = int'(MAXL);
                else if (r == 2) f.len = int'(MAXL) + int'($urandom_range(1, 8));
                else f.len = int'($urandom_range(2, 70));
                if (f.len >= 2 && $urandom_range(0, 4) == 0) begin
                    f.stall_at = int'($urandom_range(1, f.len - 1));
                    f.stall_n  = int'($urandom_range(1, 4));
                end else if (f.len >= 3 && i < 5 && $urandom_range(0, 4) == 0) begin
                    f.trunc_at = int'($urandom_range(1, (f.len - 1 < 10) ? f.len - 1 : 10));
                end
                if (prev_trunc) begin
                    f.orph = 0;
                    f.idle = 0;
                end
                prev_trunc = (f.trunc_at >= 0);
                f.ack_dly = int'($urandom_range(0, 4));
                model(f, n, e);
                fq.push_back(f); nq.push_back(n); eq.push_back(e);
                if (e) e_err++; else e_ok++;
                e_orph += f.orph;
            end
            run($sformatf("rnd%0d", b), fq);
            check_frames($sformatf("rnd%0d", b), fq, sat(e_ok), sat(e_err), sat(e_orph), nq, eq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
